// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular arbiter for one UART TX FIFO
// Optional feature macro: UART_ARB_TIMEOUT_EN (forced release of a stalled owner)
module uart_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int IDX_W     = 2,
   parameter int TO_CYCLES = 1000,
   parameter int TO_W      = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] data,
   input  logic [NREQ-1:0]   last,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   input  logic              tx_full,
   output logic              wr_uart,
   output logic [7:0]        w_data
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] owner_inc;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;
   logic [IDX_W:0]   idx_sum;
   logic             owner_req;
   logic             owner_last;
   logic [7:0]       owner_data;
   logic             to_expire;

   assign owner_req  = req[owner];
   assign owner_last = last[owner];
   assign owner_data = data[{owner, 3'b000} +: 8];
   assign owner_inc  = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;

   // Only the owner's byte ever reaches the FIFO; tx_full of this very cycle gates the write.
   assign wr_uart = (state == SEND) & owner_req & ~tx_full;
   assign w_data  = (state == SEND) ? owner_data : 8'h00;

   // Accept pulse goes back to the owner only.
   always_comb begin
      ack = '0;
      if (wr_uart) begin
         ack[owner] = 1'b1;
      end
   end

   // Round-robin pick: first requester at ptr, ptr+1, ... wrapping; scanning downward lets the nearest win.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      idx_sum    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (idx_sum >= (IDX_W + 1)'(NREQ)) begin
            idx_sum = idx_sum - (IDX_W + 1)'(NREQ);
         end
         if (req[idx_sum[IDX_W-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = idx_sum[IDX_W-1:0];
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   assign to_expire = (state == SEND) && !owner_req && (to_cnt == TO_W'(TO_CYCLES - 1));

   // Count owner-silent cycles; any accept or leaving SEND restarts the count, tx_full stalls hold it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (state != SEND || wr_uart || to_expire) begin
         to_cnt <= '0;
      end else if (!owner_req) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   localparam int to_unused = TO_CYCLES + TO_W;

   assign to_expire = 1'b0;
`endif

   // Message-level FSM: grab an owner in IDLE, hold it until its last byte is accepted (or timeout).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
         grant <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  owner <= pick_idx;
                  grant <= {{(NREQ - 1){1'b0}}, 1'b1} << pick_idx;
                  busy  <= 1'b1;
                  state <= SEND;
               end
            end
            SEND: begin
               if ((wr_uart && owner_last) || to_expire) begin
                  ptr   <= owner_inc;
                  grant <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
